// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM port arbiter: requester indices,
// arbiter FSM state encoding and small id helpers.
package dram_arb_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_ID_W = 2;

  localparam logic [REQ_ID_W-1:0] REQ_FETCH = 2'd0;
  localparam logic [REQ_ID_W-1:0] REQ_LOAD  = 2'd1;
  localparam logic [REQ_ID_W-1:0] REQ_STORE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN,
    ST_DONE
  } arb_state_t;

  // One-hot vector selecting requester id (all zero for an out-of-range id).
  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [REQ_ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (int'(id) < NUM_REQ) v[id] = 1'b1;
    return v;
  endfunction

  // Round-robin successor of a requester id.
  function automatic logic [REQ_ID_W-1:0] next_id(input logic [REQ_ID_W-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + REQ_ID_W'(1);
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and DRAM-side signals of the arbiter, bundled so the
// arbiter and its environment connect through one port.
// slave  : arbiter view
// master : requesters + DRAM model view
interface dram_port_arbiter_if
  import dram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) ();

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0]                 wready;
  logic [NUM_REQ-1:0]                 rvalid;
  logic [DATA_WIDTH-1:0]              rdata;
  logic [NUM_REQ-1:0]                 done;
  logic                               mem_en;
  logic                               mem_we;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic [DATA_WIDTH-1:0]              mem_wdata;
  logic [DATA_WIDTH-1:0]              mem_rdata;
  logic [31:0]                        wait_cycles;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, mem_rdata,
    output gnt, wready, rvalid, rdata, done,
           mem_en, mem_we, mem_addr, mem_wdata, wait_cycles
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, mem_rdata,
    input  gnt, wready, rvalid, rdata, done,
           mem_en, mem_we, mem_addr, mem_wdata, wait_cycles
  );

endinterface

// File: rtl/dram_port_arbiter_rr_priority_picker.sv
// Combinational round-robin winner: first valid requester found when
// scanning upward from ptr, wrapping past the last index.
module rr_priority_picker
  import dram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]  i_valid,
  input  logic [REQ_ID_W-1:0] i_ptr,
  output logic                o_any,
  output logic [REQ_ID_W-1:0] o_id
);

  logic [REQ_ID_W:0]   w_sum;
  logic [REQ_ID_W-1:0] w_cand;

  // Scan from farthest to nearest offset so the nearest valid one wins.
  always_comb begin
    o_any  = 1'b0;
    o_id   = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum  = {1'b0, i_ptr} + (REQ_ID_W+1)'(k);
      w_cand = (w_sum >= (REQ_ID_W+1)'(NUM_REQ)) ?
               REQ_ID_W'(w_sum - (REQ_ID_W+1)'(NUM_REQ)) : w_sum[REQ_ID_W-1:0];
      if (i_valid[w_cand]) begin
        o_any = 1'b1;
        o_id  = w_cand;
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Three-port DRAM burst arbiter (fetch / load / store) with round-robin
// grant, one beat per cycle and fixed 1-cycle DRAM read latency.
// Optional wait-cycle perf counter: define DRAM_ARB_PERF_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no burst; pick a winner, latch its request
// ST_BURST | one DRAM beat per cycle, remaining-beat down-counter
// ST_DRAIN | read bursts only: last read beat returns from DRAM
// ST_DONE  | done pulse; a zero-length burst holds here one extra cycle
//          | so its grant pulse precedes its done pulse
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) (
  input logic                clk,
  input logic                rst,
  dram_port_arbiter_if.slave bus
);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [REQ_ID_W-1:0] r_ptr;
  logic [REQ_ID_W-1:0] r_id;
  logic [REQ_ID_W-1:0] w_pick_id;
  logic                w_pick_any;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                r_write;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [NUM_REQ-1:0]  w_id_oh;
  logic                w_last_beat;

  rr_priority_picker u_picker (
    .i_valid (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_any   (w_pick_any),
    .o_id    (w_pick_id)
  );

  assign w_id_oh     = id_onehot(r_id);
  assign w_last_beat = (r_remain == LEN_WIDTH'(1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Latch the winning request, then walk address up / remaining beats down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_id     <= REQ_FETCH;
      r_addr   <= '0;
      r_remain <= '0;
      r_write  <= 1'b0;
      r_gnt    <= '0;
    end else begin
      r_gnt <= '0;
      if (r_state == ST_IDLE && w_pick_any) begin
        r_id     <= w_pick_id;
        r_addr   <= bus.req_addr[w_pick_id];
        r_remain <= bus.req_len[w_pick_id];
        r_write  <= bus.req_write[w_pick_id];
        r_gnt    <= id_onehot(w_pick_id);
        r_ptr    <= next_id(w_pick_id);
      end else if (r_state == ST_BURST) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_remain <= r_remain - LEN_WIDTH'(1);
      end
    end
  end

  // Read data comes back one cycle after each read beat.
  always_ff @(posedge clk) begin
    if (rst) r_rvalid <= '0;
    else     r_rvalid <= (r_state == ST_BURST && !r_write) ? w_id_oh : '0;
  end

  // Next state and all arbiter outputs; only the granted requester's lanes move.
  always_comb begin
    w_next_state  = r_state;
    bus.gnt       = r_gnt;
    bus.rvalid    = r_rvalid;
    bus.rdata     = (|r_rvalid) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
    bus.wready    = '0;
    bus.done      = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = {DATA_WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          if (bus.req_len[w_pick_id] == '0) w_next_state = ST_DONE;
          else                              w_next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = r_write;
        bus.mem_addr = r_addr;
        if (r_write) begin
          bus.wready    = w_id_oh;
          bus.mem_wdata = bus.req_wdata[r_id];
        end
        if (w_last_beat) w_next_state = r_write ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (r_gnt == '0) begin
          bus.done     = w_id_oh;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

`ifdef DRAM_ARB_PERF_EN
  logic [31:0]        r_wait_cycles;
  logic [NUM_REQ-1:0] w_busy_mask;

  assign w_busy_mask = (r_state != ST_IDLE) ? w_id_oh : '0;

  // Count cycles where someone is asking but is not the requester being served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cycles <= '0;
    end else if (|(bus.req_valid & ~w_busy_mask) && (r_wait_cycles != '1)) begin
      r_wait_cycles <= r_wait_cycles + 32'd1;
    end
  end

  assign bus.wait_cycles = r_wait_cycles;
`else
  assign bus.wait_cycles = '0;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: table of single bursts,
// round-robin sequence, and reset-mid-burst sequence, all scored against
// queues of expected beats, read data, grants and done pulses.
module tb_dram_port_arbiter;
  import dram_arb_pkg::*;

  localparam int AW = 24;
  localparam int DW = 8;
  localparam int LW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            id;
  } beat_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rd_t;

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    int            len;
    logic [DW-1:0] wbase;
    int            exp_lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  beat_t      beat_q[$];
  rd_t        rd_q[$];
  logic [2:0] gnt_q[$];
  logic [2:0] done_q[$];
  vec_t       vecs[6];

  dram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  dram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2:0] oh(input int id);
    return 3'b001 << id;
  endfunction

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [63:0] out_vec();
    return {10'd0, bus.gnt, bus.wready, bus.rvalid, bus.rdata, bus.done,
            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // DRAM model: 1-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_f(bus.mem_addr);
  end

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    beat_t b;
    rd_t   r;
    logic [2:0] g;
    if (!rst) begin
      if (bus.mem_en) begin
        if (beat_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: mem_addr=0x%0h, no access expected", bus.mem_addr);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr",   64'(bus.mem_addr),  64'(b.addr));
          check("beat_we",     64'(bus.mem_we),    64'(b.we));
          check("beat_wdata",  64'(bus.mem_wdata), 64'(b.wdata));
          check("beat_wready", 64'(bus.wready),    64'(b.we ? oh(b.id) : 3'b000));
        end
      end
      if (|bus.rvalid) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rvalid: rvalid=0x%0h, none expected", bus.rvalid);
        end else begin
          r = rd_q.pop_front();
          check("rvalid", 64'(bus.rvalid), 64'(oh(r.id)));
          check("rdata",  64'(bus.rdata),  64'(r.data));
        end
      end
      if (|bus.gnt) begin
        if (gnt_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_gnt: gnt=0x%0h, none expected", bus.gnt);
        end else begin
          g = gnt_q.pop_front();
          check("gnt", 64'(bus.gnt), 64'(g));
        end
      end
      if (|bus.done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: done=0x%0h, none expected", bus.done);
        end else begin
          g = done_q.pop_front();
          check("done", 64'(bus.done), 64'(g));
        end
      end
    end
  end

  task automatic run_burst(input vec_t v);
    logic [AW-1:0] a;
    int t, tg, td;
    gnt_q.push_back(oh(v.id));
    done_q.push_back(oh(v.id));
    for (int b = 0; b < v.len; b++) begin
      a = v.addr + AW'(b);
      beat_q.push_back('{a, v.wr, v.wr ? v.wbase + DW'(b) : 8'h00, v.id});
      if (!v.wr) rd_q.push_back('{v.id, mem_f(a)});
    end
    @(posedge clk); #1;
    bus.req_valid[v.id] = 1'b1;
    bus.req_write[v.id] = v.wr;
    bus.req_addr[v.id]  = v.addr;
    bus.req_len[v.id]   = LW'(v.len);
    bus.req_wdata[v.id] = v.wbase;
    t = 0; tg = -1; td = -1;
    while (td < 0 && t < v.len + 30) begin
      @(negedge clk);
      if (tg < 0 && bus.gnt[v.id]) tg = t;
      if (bus.done[v.id]) td = t;
      #1;
      if (tg >= 0) begin
        // changes after the grant must not affect the latched burst
        bus.req_valid[v.id] = 1'b0;
        bus.req_addr[v.id]  = ~v.addr;
        bus.req_len[v.id]   = LW'(3);
        bus.req_write[v.id] = ~v.wr;
      end
      if (bus.wready[v.id]) bus.req_wdata[v.id] = bus.req_wdata[v.id] + 8'd1;
      t++;
    end
    if (tg < 0 || td < 0) begin
      n_checks++; n_fail++;
      $display("FAIL burst_timeout: id=%0d gnt_seen=%0d done_seen=%0d, both required", v.id, tg >= 0, td >= 0);
    end else begin
      check("gnt_to_done", 64'(td - tg), 64'(v.exp_lat));
    end
  endtask

  task automatic rr_sequence();
    logic [AW-1:0] a;
    int t, ng, nd, last_done;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3; i++) begin
        a = AW'(16 * (i + 1));
        gnt_q.push_back(oh(i));
        beat_q.push_back('{a, 1'b0, 8'h00, i});
        rd_q.push_back('{i, mem_f(a)});
        done_q.push_back(oh(i));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_write[i] = 1'b0;
      bus.req_addr[i]  = AW'(16 * (i + 1));
      bus.req_len[i]   = LW'(1);
    end
    t = 0; ng = 0; nd = 0; last_done = -100;
    while (nd < 6 && t < 200) begin
      @(negedge clk);
      if (|bus.gnt) begin
        ng++;
        if (ng > 1) check("done_to_next_gnt", 64'(t - last_done), 64'd2);
      end
      if (|bus.done) begin
        nd++;
        last_done = t;
      end
      #1;
      if (ng == 6) bus.req_valid = '0;
      t++;
    end
    if (nd < 6) begin
      n_checks++; n_fail++;
      $display("FAIL rr_timeout: done pulses=%0d required 6", nd);
    end
  endtask

  task automatic reset_midburst();
    int t, tg;
    bit hit;
    gnt_q.push_back(3'b100);
    for (int b = 0; b < 4; b++) beat_q.push_back('{AW'(24'h400 + b), 1'b0, 8'h00, 2});
    for (int b = 0; b < 3; b++) rd_q.push_back('{2, mem_f(AW'(24'h400 + b))});
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b1;
    bus.req_write[2] = 1'b0;
    bus.req_addr[2]  = 24'h000400;
    bus.req_len[2]   = LW'(8);
    t = 0; tg = -1; hit = 1'b0;
    while (!hit && t < 40) begin
      @(negedge clk);
      if (tg < 0 && bus.gnt[2]) tg = t;
      #1;
      if (tg >= 0) bus.req_valid[2] = 1'b0;
      if (tg >= 0 && t - tg == 3) begin
        rst = 1'b1;
        hit = 1'b1;
      end
      t++;
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL midburst_gnt_timeout: no grant for store, grant required");
      rst = 1'b1;
    end
    @(negedge clk);
    check("rst_midburst_outputs", out_vec(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("rst_beats_pending", 64'(beat_q.size()), 64'd0);
    check("rst_rd_pending",    64'(rd_q.size()),   64'd0);

    gnt_q.push_back(3'b001);
    done_q.push_back(3'b001);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_write[i] = 1'b0;
      bus.req_len[i]   = '0;
    end
    t = 0; hit = 1'b0;
    while (!hit && t < 20) begin
      @(negedge clk);
      if (|bus.gnt) begin
        hit = 1'b1;
        check("post_reset_first_gnt", 64'(bus.gnt), 64'(3'b001));
      end
      #1;
      if (hit) bus.req_valid = '0;
      t++;
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL post_reset_gnt_timeout: no grant, grant to index 0 required");
    end
    t = 0;
    while (done_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 24'h000100, 8, 8'h00, 9};
    vecs[1] = '{2, 1'b1, 24'h002000, 4, 8'h11, 4};
    vecs[2] = '{1, 1'b0, 24'h000500, 0, 8'h00, 1};
    vecs[3] = '{1, 1'b0, 24'hFFFFFE, 4, 8'h00, 5};
    vecs[4] = '{0, 1'b1, 24'hFFFFFF, 3, 8'hA0, 3};
    vecs[5] = '{2, 1'b0, 24'h000055, 1, 8'h00, 2};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",     out_vec(),              64'd0);
    check("reset_wait_cycles", 64'(bus.wait_cycles),   64'd0);
    @(posedge clk); #1 rst = 1'b0;

    rr_sequence();
`ifdef DRAM_ARB_PERF_EN
    check("wait_cycles_counted", 64'(bus.wait_cycles != 32'd0), 64'd1);
`else
    check("wait_cycles_zero", 64'(bus.wait_cycles), 64'd0);
`endif

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    reset_midburst();

    repeat (5) @(negedge clk);
    check("drain_beats", 64'(beat_q.size()), 64'd0);
    check("drain_rd",    64'(rd_q.size()),   64'd0);
    check("drain_gnt",   64'(gnt_q.size()),  64'd0);
    check("drain_done",  64'(done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24: DRAM byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: DRAM data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 10: burst-length field width, matching decoder length/rows fields.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  [NUM_REQ]  burst request; index 0 fetch, 1 load, 2 store.
REQ-007 SHALL have port req_write  input  [NUM_REQ]  1 = write burst, 0 = read burst.
REQ-008 SHALL have port req_addr  input  [NUM_REQ][ADDR_WIDTH]  burst base address.
REQ-009 SHALL have port req_len  input  [NUM_REQ][LEN_WIDTH]  beat count.
REQ-010 SHALL have port req_wdata  input  [NUM_REQ][DATA_WIDTH]  write data for current beat.
REQ-011 SHALL have port gnt  output  [NUM_REQ]  one-cycle grant pulse.
REQ-012 SHALL have port wready  output  [NUM_REQ]  write beat consumed this cycle.
REQ-013 SHALL have port rvalid  output  [NUM_REQ]  rdata valid for that requester.
REQ-014 SHALL have port rdata  output  DATA_WIDTH  read data, shared by all requesters.
REQ-015 SHALL have port done  output  [NUM_REQ]  one-cycle burst-complete pulse.
REQ-016 SHALL have port mem_en/mem_we  output  1/1  DRAM access enable / write enable.
REQ-017 SHALL have port mem_addr/mem_wdata  output  ADDR_WIDTH/DATA_WIDTH  DRAM address / write data.
REQ-018 SHALL have port mem_rdata  input  DATA_WIDTH  DRAM read data, fixed 1-cycle latency after mem_en.
REQ-019 SHALL have port wait_cycles  output  32  perf counter (see Configuration).

Function
REQ-020 SHALL implement FSM IDLE -> BURST -> (DRAIN, reads only) -> DONE -> IDLE.
REQ-021 IDLE: if any req_valid, pick winner round-robin starting at pointer ptr; latch id, addr, len, write; go BURST; gnt[id]=1 in first BURST cycle.
REQ-022 After each grant, ptr SHALL become (id+1) mod NUM_REQ.
REQ-023 BURST: one beat per cycle, mem_en=1, mem_we=write, mem_addr=base+beat; beat counts 0..len-1.
REQ-024 Write beats SHALL drive mem_wdata=req_wdata[id] combinationally with wready[id]=1 in the same cycle.
REQ-025 Read beats SHALL produce rvalid[id]=1, rdata=mem_rdata one cycle after each beat's mem_en.
REQ-026 After the last beat: write -> DONE; read -> DRAIN (1 cycle, last rvalid) -> DONE.
REQ-027 DONE SHALL pulse done[id] for one cycle, then return to IDLE; earliest next grant is 2 cycles after done.
REQ-028 req_len==0 SHALL grant, skip BURST (no mem_en), go DONE directly.
REQ-029 Address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-030 req_valid deassertion or input changes mid-burst SHALL be ignored; latched burst completes.
REQ-031 Outputs for non-granted requesters SHALL remain 0 at all times.

Reset
REQ-032 rst SHALL return FSM to IDLE, ptr to 0, abort any burst; all outputs 0 in the cycle after rst is sampled high.

Configuration
REQ-033 Macro DRAM_ARB_PERF_EN defined: wait_cycles increments each cycle with some req_valid high but no burst for that requester, saturating at 2^32-1, cleared by rst.
REQ-034 DRAM_ARB_PERF_EN undefined: wait_cycles SHALL be constant 0, no counter logic.

Structure
REQ-035 Package dram_arb_pkg SHALL hold NUM_REQ=3, REQ_FETCH/REQ_LOAD/REQ_STORE indices, FSM state enum.
REQ-036 Sub-module rr_priority_picker SHALL compute the combinational round-robin winner from req_valid and ptr.

Verification
REQ-037 Fetch read len=8 addr=0x000100 alone -> gnt[0] once, mem_addr 0x100..0x107, 8 rvalid[0], done[0] 1 cycle after last rvalid.
REQ-038 All three req_valid in same cycle after reset -> grant order 0,1,2; then with all held, order repeats 0,1,2.
REQ-039 Store write len=4 data 0x11..0x14 -> 4 wready[2], mem_we=1, mem_wdata 0x11..0x14 consecutive, done[2].
REQ-040 Load len=0 -> gnt[1], done[1] next cycle, mem_en never high.
REQ-041 rst asserted mid-burst at beat 3 of 8 -> all outputs 0 next cycle, no done, next grant goes to index 0.
REQ-042 addr=0xFFFFFE len=4 -> mem_addr 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
